// File: rtl/match_flow_controller.sv
// -----------------------------------------------------------------------------
// match_flow_controller
// Sequences one badminton match: start, serve, rally, point award,
// inter-point pause and match end. Holds both scores and the current server,
// judges the win condition and drives the win levels for settlement logic.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous reset, active-HIGH (legacy name kept)
//   start         pulse; begins a match from IDLE or FINISHED
//   frame_tick    pulse once per video frame; paces the inter-point pause
//   serve_done    pulse; server struck the shuttle
//   land_valid    pulse; shuttle landed or was faulted
//   land_side     0 = landed on A side (B scores), 1 = landed on B side (A scores)
//   score_a/b     player scores
//   server        0 = A serves, 1 = B serves
//   phase         IDLE=0, SERVE=1, RALLY=2, PAUSE=3, FINISHED=4
//   serve_enable  high only in SERVE
//   player1_win   high while FINISHED and A won
//   player2_win   high while FINISHED and B won
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, waiting for start
// SERVE    | waiting for the server to strike
// RALLY    | shuttle in play, waiting for landing
// PAUSE    | counting frame ticks between points
// FINISHED | match decided, scores and win level held until start
// -----------------------------------------------------------------------------
module match_flow_controller #(
  parameter int WIN_SCORE    = 21,
  parameter int CAP_SCORE    = 30,
  parameter int PAUSE_FRAMES = 60,
  parameter int SCORE_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               serve_done,
  input  logic               land_valid,
  input  logic               land_side,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               server,
  output logic [2:0]         phase,
  output logic               serve_enable,
  output logic               player1_win,
  output logic               player2_win
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    RALLY    = 3'd2,
    PAUSE    = 3'd3,
    FINISHED = 3'd4
  } phase_e;

  localparam int CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [SCORE_W:0]   WIN_X    = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] CAP_S    = SCORE_W'(CAP_SCORE);

  phase_e             state_q, state_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               server_q, server_d;
  logic               p1_win_q, p1_win_d;
  logic               p2_win_q, p2_win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Point evaluation for the player whose side did not receive the shuttle.
  logic [SCORE_W-1:0] win_new;
  logic [SCORE_W-1:0] opp_score;
  logic [SCORE_W:0]   n_x;
  logic [SCORE_W:0]   o_x;
  logic               is_win;

  always_comb begin
    win_new   = land_side ? (score_a_q + SCORE_W'(1)) : (score_b_q + SCORE_W'(1));
    opp_score = land_side ? score_b_q : score_a_q;
    n_x       = {1'b0, win_new};
    o_x       = {1'b0, opp_score};
    // Lead test written as n >= o + 2 in the widened domain so it cannot wrap.
    is_win    = ((n_x >= WIN_X) && (n_x >= (o_x + (SCORE_W + 1)'(2)))) ||
                (win_new == CAP_S);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      score_a_q <= '0;
      score_b_q <= '0;
      server_q  <= 1'b0;
      p1_win_q  <= 1'b0;
      p2_win_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      server_q  <= server_d;
      p1_win_q  <= p1_win_d;
      p2_win_q  <= p2_win_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    server_d  = server_q;
    p1_win_d  = p1_win_q;
    p2_win_d  = p2_win_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE, FINISHED: begin
        if (start) begin
          state_d   = SERVE;
          score_a_d = '0;
          score_b_d = '0;
          server_d  = 1'b0;
          p1_win_d  = 1'b0;
          p2_win_d  = 1'b0;
        end
      end

      SERVE: begin
        if (serve_done) state_d = RALLY;
      end

      RALLY: begin
        if (land_valid) begin
          if (land_side) score_a_d = win_new;
          else           score_b_d = win_new;
          server_d = ~land_side;
          if (is_win) begin
            state_d  = FINISHED;
            p1_win_d = land_side;
            p2_win_d = ~land_side;
          end else begin
            state_d = PAUSE;
            cnt_d   = '0;
          end
        end
      end

      PAUSE: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign score_a      = score_a_q;
  assign score_b      = score_b_q;
  assign server       = server_q;
  assign phase        = state_q;
  assign serve_enable = (state_q == SERVE);
  assign player1_win  = p1_win_q;
  assign player2_win  = p2_win_q;

endmodule

// File: tb/tb_match_flow_controller.sv
// -----------------------------------------------------------------------------
// tb_match_flow_controller
// Directed scenarios plus a randomized run, each checked against a
// match-level reference model kept in integers (scores, server, phase,
// win flags, pause ticks remaining).
// -----------------------------------------------------------------------------
module tb_match_flow_controller;

  localparam int PF = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, frame_tick, serve_done, land_valid, land_side;
  logic [4:0] score_a, score_b;
  logic       server;
  logic [2:0] phase;
  logic       serve_enable, player1_win, player2_win;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  int m_a, m_b, m_srv, m_phase, m_p1, m_p2, m_ticks;

  match_flow_controller #(
    .WIN_SCORE(21), .CAP_SCORE(30), .PAUSE_FRAMES(PF), .SCORE_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_tick(frame_tick),
    .serve_done(serve_done), .land_valid(land_valid), .land_side(land_side),
    .score_a(score_a), .score_b(score_b), .server(server), .phase(phase),
    .serve_enable(serve_enable), .player1_win(player1_win),
    .player2_win(player2_win)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_srv = 0; m_phase = 0; m_p1 = 0; m_p2 = 0; m_ticks = 0;
  endtask

  // Match rules applied to one cycle's worth of input pulses.
  task automatic model_step(input logic st, fr, sd, lv, ls);
    int n, o;
    case (m_phase)
      0, 4: if (st) begin
        m_phase = 1; m_a = 0; m_b = 0; m_srv = 0; m_p1 = 0; m_p2 = 0;
      end
      1: if (sd) m_phase = 2;
      2: if (lv) begin
        if (ls) begin m_a = m_a + 1; n = m_a; o = m_b; m_srv = 0; end
        else    begin m_b = m_b + 1; n = m_b; o = m_a; m_srv = 1; end
        if ((n >= 21 && n - o >= 2) || n == 30) begin
          m_phase = 4;
          if (ls) m_p1 = 1; else m_p2 = 1;
        end else begin
          m_phase = 3;
          m_ticks = 0;
        end
      end
      3: if (fr) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == PF) m_phase = 1;
      end
      default: ;
    endcase
  endtask

  // Drive one clock of inputs (from a falling edge), leave time at the next
  // falling edge so outputs are sampled mid-cycle.
  task automatic cycle(input logic st, fr, sd, lv, ls);
    start = st; frame_tick = fr; serve_done = sd; land_valid = lv; land_side = ls;
    @(negedge clk);
    model_step(st, fr, sd, lv, ls);
    start = 1'b0; frame_tick = 1'b0; serve_done = 1'b0; land_valid = 1'b0;
  endtask

  task automatic rally(input logic side);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, side);
  endtask

  task automatic run_pause();
    repeat (PF) begin
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
    end
  endtask

  task automatic point(input logic side);
    rally(side);
    if (m_phase == 3) run_pause();
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    start = 0; frame_tick = 0; serve_done = 0; land_valid = 0; land_side = 0;
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({score_a, score_b, server, phase, serve_enable, player1_win, player2_win} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: got a=%0d b=%0d srv=%0d ph=%0d se=%0d w=%0d%0d, want all 0",
               score_a, score_b, server, phase, serve_enable, player1_win, player2_win);
    end
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shutout();
    cycle(1, 0, 0, 0, 0);
    n_cmp++;
    if (phase !== 3'd1 || serve_enable !== 1'b1) begin
      n_err++;
      $display("FAIL start_to_serve: got ph=%0d se=%0d, want ph=1 se=1", phase, serve_enable);
    end
    for (int i = 1; i <= 21; i++) begin
      rally(1'b1);
      n_cmp++;
      if (score_a !== 5'(i) || score_b !== 5'd0 || player2_win !== 1'b0) begin
        n_err++;
        $display("FAIL shutout_point%0d: got a=%0d b=%0d w2=%0d, want a=%0d b=0 w2=0",
                 i, score_a, score_b, player2_win, i);
      end
      if (i < 21) run_pause();
    end
    n_cmp++;
    if (phase !== 3'd4 || player1_win !== 1'b1 || player2_win !== 1'b0) begin
      n_err++;
      $display("FAIL shutout_finish: got ph=%0d w1=%0d w2=%0d, want ph=4 w1=1 w2=0",
               phase, player1_win, player2_win);
    end
  endtask

  task automatic test_deuce();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      point(1'b1);
      point(1'b0);
    end
    n_cmp++;
    if (score_a !== 5'd20 || score_b !== 5'd20 || phase !== 3'd1) begin
      n_err++;
      $display("FAIL deuce_setup: got %0d-%0d ph=%0d, want 20-20 ph=1", score_a, score_b, phase);
    end
    rally(1'b1);
    n_cmp++;
    if (score_a !== 5'd21 || score_b !== 5'd20 || phase !== 3'd3 || player1_win !== 1'b0) begin
      n_err++;
      $display("FAIL deuce_21_20: got %0d-%0d ph=%0d w1=%0d, want 21-20 ph=3 w1=0",
               score_a, score_b, phase, player1_win);
    end
    run_pause();
    rally(1'b0);
    n_cmp++;
    if (score_a !== 5'd21 || score_b !== 5'd21 || phase !== 3'd3 || server !== 1'b1) begin
      n_err++;
      $display("FAIL deuce_21_21: got %0d-%0d ph=%0d srv=%0d, want 21-21 ph=3 srv=1",
               score_a, score_b, phase, server);
    end
    run_pause();
    rally(1'b1);
    n_cmp++;
    if (score_a !== 5'd22 || phase !== 3'd3) begin
      n_err++;
      $display("FAIL deuce_22_21: got a=%0d ph=%0d, want a=22 ph=3", score_a, phase);
    end
    run_pause();
    rally(1'b1);
    n_cmp++;
    if (score_a !== 5'd23 || score_b !== 5'd21 || phase !== 3'd4 ||
        player1_win !== 1'b1 || player2_win !== 1'b0) begin
      n_err++;
      $display("FAIL deuce_finish: got %0d-%0d ph=%0d w=%0d%0d, want 23-21 ph=4 w=10",
               score_a, score_b, phase, player1_win, player2_win);
    end
  endtask

  task automatic test_cap();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 29; i++) begin
      point(1'b1);
      point(1'b0);
    end
    n_cmp++;
    if (score_a !== 5'd29 || score_b !== 5'd29 || phase !== 3'd1) begin
      n_err++;
      $display("FAIL cap_setup: got %0d-%0d ph=%0d, want 29-29 ph=1", score_a, score_b, phase);
    end
    rally(1'b0);
    n_cmp++;
    if (score_b !== 5'd30 || score_a !== 5'd29 || player2_win !== 1'b1 ||
        player1_win !== 1'b0 || phase !== 3'd4 || server !== 1'b1) begin
      n_err++;
      $display("FAIL cap_finish: got %0d-%0d w=%0d%0d ph=%0d srv=%0d, want 29-30 w=01 ph=4 srv=1",
               score_a, score_b, player1_win, player2_win, phase, server);
    end
    // Finished: other inputs must not move anything.
    cycle(0, 1, 1, 1, 1);
    n_cmp++;
    if (score_b !== 5'd30 || player2_win !== 1'b1 || phase !== 3'd4) begin
      n_err++;
      $display("FAIL finished_hold: got b=%0d w2=%0d ph=%0d, want b=30 w2=1 ph=4",
               score_b, player2_win, phase);
    end
  endtask

  task automatic test_restart_finished();
    cycle(1, 0, 0, 0, 0);
    n_cmp++;
    if (score_a !== 5'd0 || score_b !== 5'd0 || player1_win !== 1'b0 ||
        player2_win !== 1'b0 || phase !== 3'd1 || server !== 1'b0) begin
      n_err++;
      $display("FAIL restart: got %0d-%0d w=%0d%0d ph=%0d srv=%0d, want 0-0 w=00 ph=1 srv=0",
               score_a, score_b, player1_win, player2_win, phase, server);
    end
  endtask

  task automatic test_pause_timing();
    rally(1'b0);
    n_cmp++;
    if (phase !== 3'd3 || serve_enable !== 1'b0) begin
      n_err++;
      $display("FAIL pause_entry: got ph=%0d se=%0d, want ph=3 se=0", phase, serve_enable);
    end
    for (int k = 1; k <= PF; k++) begin
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 1, 0, 0, 0);
      n_cmp++;
      if (phase !== ((k < PF) ? 3'd3 : 3'd1) || score_a !== 5'd0 || score_b !== 5'd1) begin
        n_err++;
        $display("FAIL pause_tick%0d: got ph=%0d %0d-%0d, want ph=%0d 0-1",
                 k, phase, score_a, score_b, (k < PF) ? 3 : 1);
      end
    end
  endtask

  task automatic test_serve_land_coincide();
    cycle(0, 0, 1, 1, 1);
    n_cmp++;
    if (phase !== 3'd2 || score_a !== 5'd0 || score_b !== 5'd1) begin
      n_err++;
      $display("FAIL serve_land_same: got ph=%0d %0d-%0d, want ph=2 0-1", phase, score_a, score_b);
    end
    cycle(1, 0, 0, 0, 0);
    n_cmp++;
    if (phase !== 3'd2 || score_b !== 5'd1) begin
      n_err++;
      $display("FAIL start_in_rally: got ph=%0d b=%0d, want ph=2 b=1", phase, score_b);
    end
    cycle(0, 0, 0, 1, 1);
    run_pause();
  endtask

  task automatic test_reset_mid_rally();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      point(1'b1);
      point(1'b0);
    end
    point(1'b1);
    point(1'b1);
    cycle(0, 0, 1, 0, 0);
    n_cmp++;
    if (score_a !== 5'd7 || score_b !== 5'd5 || phase !== 3'd2) begin
      n_err++;
      $display("FAIL midrally_setup: got %0d-%0d ph=%0d, want 7-5 ph=2", score_a, score_b, phase);
    end
    land_valid = 1'b1; land_side = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    land_valid = 1'b0;
    model_reset();
    n_cmp++;
    if (phase !== 3'd0 || score_a !== 5'd0 || score_b !== 5'd0 ||
        player1_win !== 1'b0 || player2_win !== 1'b0) begin
      n_err++;
      $display("FAIL midrally_reset: got ph=%0d %0d-%0d w=%0d%0d, want ph=0 0-0 w=00",
               phase, score_a, score_b, player1_win, player2_win);
    end
    rst_n = 1'b0;
    cycle(0, 0, 1, 1, 1);
    n_cmp++;
    if (phase !== 3'd0 || score_a !== 5'd0) begin
      n_err++;
      $display("FAIL after_reset_idle: got ph=%0d a=%0d, want ph=0 a=0", phase, score_a);
    end
  endtask

  task automatic test_random();
    logic st, fr, sd, lv, ls;
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      st = ($urandom_range(0, 149) == 0) || (m_phase == 0 && $urandom_range(0, 3) == 0)
           || (m_phase == 4 && $urandom_range(0, 7) == 0);
      fr = ($urandom_range(0, 2) == 0);
      sd = ($urandom_range(0, 3) == 0);
      lv = ($urandom_range(0, 3) == 0);
      ls = 1'($urandom_range(0, 1));
      cycle(st, fr, sd, lv, ls);
      n_cmp++;
      if ({score_a, score_b, server, phase, serve_enable, player1_win, player2_win} !==
          {5'(m_a), 5'(m_b), 1'(m_srv), 3'(m_phase), (m_phase == 1), 1'(m_p1), 1'(m_p2)}) begin
        n_err++;
        $display("FAIL random_c%0d: got %0d-%0d srv=%0d ph=%0d se=%0d w=%0d%0d, want %0d-%0d srv=%0d ph=%0d se=%0d w=%0d%0d",
                 c, score_a, score_b, server, phase, serve_enable, player1_win, player2_win,
                 m_a, m_b, m_srv, m_phase, (m_phase == 1), m_p1, m_p2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shutout();
    test_deuce();
    test_cap();
    test_restart_finished();
    test_pause_timing();
    test_serve_land_coincide();
    test_reset_mid_rally();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/match_flow_controller.md
Name: match_flow_controller

Overview:
Sequences one badminton match: start, serve, rally, point award, inter-point pause and match end. It keeps both scores and the server. It judges the win condition and drives the player1_win / player2_win levels consumed by the game-finish/settlement logic. Sits between the shuttle physics/collision logic (landing and serve events) and the settlement-page/HUD logic.

Parameters:
WIN_SCORE, 21, minimum score to win (2-point lead required)
CAP_SCORE, 30, score that wins outright regardless of lead
PAUSE_FRAMES, 60, frame_tick count spent in PAUSE after each non-final point
SCORE_W, 5, score width; must hold CAP_SCORE

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-high
start  in  1  1-cycle pulse; begins match from IDLE or FINISHED
frame_tick  in  1  1-cycle pulse once per video frame
serve_done  in  1  1-cycle pulse; server has struck the shuttle
land_valid  in  1  1-cycle pulse; shuttle landed or was faulted
land_side  in  1  court where it landed: 0 = player A side (B scores), 1 = player B side (A scores)
score_a  out  SCORE_W  player A score
score_b  out  SCORE_W  player B score
server  out  1  0 = A serves, 1 = B serves
phase  out  3  IDLE=0, SERVE=1, RALLY=2, PAUSE=3, FINISHED=4
serve_enable  out  1  high only in SERVE; gates serve input in player logic
player1_win  out  1  level; high while FINISHED and A won
player2_win  out  1  level; high while FINISHED and B won

Behaviour:
- Reset, async on rst_n=1: phase=IDLE; score_a=score_b=0; server=0; serve_enable=0; player1_win=player2_win=0; pause counter=0. Reset mid-match aborts immediately; no event is retained.
- All state is registered; outputs update on the clk edge after the causing input (1-cycle latency).
- IDLE:
  - start -> SERVE; scores 0; server=0.
- SERVE:
  - serve_done -> RALLY.
  - land_valid ignored, including when it coincides with serve_done.
- RALLY, on land_valid:
  - Winner W = land_side ? A : B. Increment W's score by 1; set server=W.
  - Let n = W's new score, o = opponent's score. Win if (n>=WIN_SCORE and n-o>=2) or n==CAP_SCORE.
  - Win -> FINISHED; set player1_win (W=A) or player2_win (W=B) in the same edge as the score update.
  - Otherwise -> PAUSE; clear pause counter.
  - serve_done in RALLY is ignored.
- PAUSE:
  - Counter increments on each frame_tick.
  - When the counter reaches PAUSE_FRAMES-1 and frame_tick=1 -> SERVE.
  - PAUSE lasts exactly PAUSE_FRAMES ticks. serve_done and land_valid are ignored.
- FINISHED:
  - Scores and win level hold.
  - start -> SERVE; scores 0; server=0; both win outputs cleared on the same edge.
  - All other inputs ignored.
- start in SERVE, RALLY or PAUSE is ignored.
- player1_win and player2_win are never both high. Both are low outside FINISHED.
- Scores never exceed CAP_SCORE. Score arithmetic is unsigned SCORE_W; the lead compare uses SCORE_W+1 bits so the subtraction cannot wrap.
- frame_tick has no effect outside PAUSE.

Test Plan:
1. Reset, start, then 21 cycles of serve_done followed by land_valid with land_side=1, running each PAUSE out -> score_a 21, score_b 0, phase=4, player1_win=1 one cycle after the 21st land_valid; player2_win stays 0.
2. Drive scores to 20-20, then A, B, A, A points -> intermediate 21-20 and 21-21 do not finish; finishes at 23-21 with player1_win=1.
3. Drive scores to 29-29, then a land_side=0 point -> score_b=30, player2_win=1, phase=4, server=1.
4. PAUSE timing with PAUSE_FRAMES=4 and frame_tick every 3 clocks -> phase returns to SERVE exactly on the 4th tick. serve_done pulses issued during PAUSE are ignored.
5. In SERVE, pulse land_valid together with serve_done -> phase=RALLY, scores unchanged. Then start during RALLY -> ignored.
6. Assert rst_n mid-RALLY at 7-5 -> next cycle phase=0, scores 0-0, wins 0. Separately, start in FINISHED -> scores 0-0, win outputs 0, phase=SERVE, server=0.
